// File: rtl/spi_xip_rd_bridge_pkg.sv
// Shared definitions for the XIP read bridge: FSM encoding, SPI mode
// selectors and default flash-read command constants.
package spi_xip_rd_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FILL  = 2'd2,
    ST_RESP  = 2'd3
  } xip_state_e;

  localparam logic       SPI_STD    = 1'b0;
  localparam logic       SPI_QUAD   = 1'b1;
  localparam logic [7:0] DEF_OPCODE = 8'hEB;
  localparam int         DEF_DUMMY  = 6;
  localparam logic [5:0] CMD_LEN    = 6'd8;

  // Rebuilds the line-aligned flash byte address from a stored tag.
  function automatic logic [31:0] line_addr(input logic [31:0] tag, input int shift);
    return tag << shift;
  endfunction

endpackage

// File: rtl/spi_xip_rd_bridge_line_buf.sv
// One-line fetch buffer: WORDS x 32-bit registers, one write port and a
// combinational read port.
module xip_line_buf #(
  parameter int WORDS = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] mem_d [WORDS];

  // Next-state of the word array: only the addressed word changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we && (32'(wr_idx) < 32'(WORDS))) begin
      mem_d[wr_idx] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Word storage, cleared by the shared reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = (32'(rd_idx) < 32'(WORDS)) ? mem_q[rd_idx] : 32'h0;

endmodule

// File: rtl/spi_xip_rd_bridge.sv
// XIP read bridge: serves bus reads from a one-line buffer and refills the
// line through the SPI master controller on a miss.
module spi_xip_rd_bridge
  import spi_xip_rd_bridge_pkg::*;
#(
  parameter int         LINE_WORDS   = 4,
  parameter int         ADDR_BITS    = 24,
  parameter logic [7:0] CMD_OPCODE   = DEF_OPCODE,
  parameter int         DUMMY_CYCLES = DEF_DUMMY,
  parameter int         QUAD         = 1,
  parameter logic [3:0] CS_SEL       = 4'b0001
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_en,
  input  logic        cfg_flush,
  input  logic        bus_req_valid,
  output logic        bus_req_ready,
  input  logic [31:0] bus_req_addr,
  output logic        bus_rsp_valid,
  input  logic        bus_rsp_ready,
  output logic [31:0] bus_rsp_rdata,
  output logic        bus_rsp_err,
  output logic [31:0] spi_cmd,
  output logic [5:0]  spi_cmd_len,
  output logic [31:0] spi_addr,
  output logic [5:0]  spi_addr_len,
  output logic [15:0] spi_data_len,
  output logic [15:0] spi_dummy_rd,
  output logic [15:0] spi_dummy_wr,
  output logic [3:0]  spi_csreg,
  output logic        spi_rd,
  output logic        spi_qrd,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        eot,
  input  logic        ctrl_idle,
  output logic        busy
);

  localparam int   OFF_BITS = $clog2(LINE_WORDS);
  localparam int   OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int   TAG_W    = ADDR_BITS - OFF_BITS - 2;
  localparam int   WCNT_W   = $clog2(LINE_WORDS + 1);
  localparam logic MODE     = (QUAD != 0) ? SPI_QUAD : SPI_STD;

  xip_state_e        state_q, state_d;
  logic              line_valid_q, line_valid_d;
  logic              flush_pend_q, flush_pend_d;
  logic              req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              rx_ready_q, rx_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [31:0]       spi_addr_q, spi_addr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic [TAG_W-1:0]  req_tag_s;
  logic [OFF_W-1:0]  req_off_s;
  logic              in_win_s, fire_s, hit_s, full_s, buf_we_s;
  logic [OFF_W-1:0]  buf_ridx_s;
  logic [31:0]       buf_rdata_s;

  // Address decode uses shifts so LINE_WORDS = 1 needs no zero-width slice.
  assign req_off_s  = OFF_W'((bus_req_addr >> 2) & 32'(LINE_WORDS - 1));
  assign req_tag_s  = TAG_W'(bus_req_addr >> (OFF_BITS + 2));
  assign in_win_s   = ((bus_req_addr >> ADDR_BITS) == 32'd0);
  assign fire_s     = bus_req_valid && req_ready_q;
  assign hit_s      = line_valid_q && (tag_q == req_tag_s);
  assign full_s     = (wcnt_q == WCNT_W'(LINE_WORDS));
  assign buf_we_s   = (state_q == ST_FILL) && rx_valid && rx_ready_q &&
                      (wcnt_q < WCNT_W'(LINE_WORDS));
  assign buf_ridx_s = (state_q == ST_RESP) ? off_q : req_off_s;

  xip_line_buf #(
    .WORDS (LINE_WORDS),
    .IDX_W (OFF_W)
  ) u_line_buf (
    .clk     (clk),
    .rstn    (rstn),
    .we      (buf_we_s),
    .wr_idx  (OFF_W'(wcnt_q)),
    .wr_data (rx_data),
    .rd_idx  (buf_ridx_s),
    .rd_data (buf_rdata_s)
  );

  // FSM next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    flush_pend_d = flush_pend_q;
    req_d        = req_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    spi_addr_d   = spi_addr_q;
    tag_d        = tag_q;
    off_d        = off_q;
    wcnt_d       = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        flush_pend_d = 1'b0;
        if (rsp_valid_q) begin
          if (bus_rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0;
          end else begin
            rsp_valid_d = 1'b1;
          end
        end else if (fire_s) begin
          if (!cfg_en || !in_win_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else if (hit_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = buf_rdata_s;
          end else begin
            tag_d        = req_tag_s;
            off_d        = req_off_s;
            spi_addr_d   = line_addr(32'(req_tag_s), OFF_BITS + 2);
            line_valid_d = 1'b0;
            wcnt_d       = '0;
            state_d      = ST_ISSUE;
          end
        end else begin
          rsp_valid_d = 1'b0;
        end
        // A hit in this same cycle was already served from line_valid_q.
        if (cfg_flush) begin
          line_valid_d = 1'b0;
        end else begin
          line_valid_d = line_valid_d;
        end
      end
      ST_ISSUE: begin
        if (cfg_flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (ctrl_idle) begin
          req_d   = 1'b1;
          state_d = ST_FILL;
        end else begin
          req_d = 1'b0;
        end
      end
      ST_FILL: begin
        if (cfg_flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (buf_we_s) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end else begin
          wcnt_d = wcnt_q;
        end
        if (eot) begin
          req_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_RESP: begin
        // First RESP cycle loads the response once the last word is stored.
        if (!rsp_valid_q) begin
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = buf_rdata_s;
          rsp_err_d    = !full_s;
          line_valid_d = full_s && !flush_pend_q && !cfg_flush;
        end else if (bus_rsp_ready) begin
          rsp_valid_d  = 1'b0;
          rsp_err_d    = 1'b0;
          rsp_rdata_d  = 32'h0;
          flush_pend_d = 1'b0;
          state_d      = ST_IDLE;
          if (cfg_flush) begin
            line_valid_d = 1'b0;
          end else begin
            line_valid_d = line_valid_q;
          end
        end else begin
          if (cfg_flush) begin
            line_valid_d = 1'b0;
          end else begin
            line_valid_d = line_valid_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign req_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
  assign rx_ready_d  = (state_d == ST_FILL);
  assign busy_d      = (state_d != ST_IDLE);

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      line_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      req_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      rx_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      spi_addr_q   <= 32'h0;
      tag_q        <= '0;
      off_q        <= '0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      flush_pend_q <= flush_pend_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      rx_ready_q   <= rx_ready_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      spi_addr_q   <= spi_addr_d;
      tag_q        <= tag_d;
      off_q        <= off_d;
      wcnt_q       <= wcnt_d;
    end
  end

  assign bus_req_ready = req_ready_q;
  assign bus_rsp_valid = rsp_valid_q;
  assign bus_rsp_rdata = rsp_rdata_q;
  assign bus_rsp_err   = rsp_err_q;
  assign rx_ready      = rx_ready_q;
  assign busy          = busy_q;
  assign spi_addr      = spi_addr_q;
  assign spi_qrd       = req_q && (MODE == SPI_QUAD);
  assign spi_rd        = req_q && (MODE == SPI_STD);

  assign spi_cmd      = {24'h0, CMD_OPCODE};
  assign spi_cmd_len  = CMD_LEN;
  assign spi_addr_len = 6'(ADDR_BITS);
  assign spi_data_len = 16'(LINE_WORDS * 32);
  assign spi_dummy_rd = 16'(DUMMY_CYCLES);
  assign spi_dummy_wr = 16'h0;
  assign spi_csreg    = CS_SEL;

endmodule

// File: tb/tb_spi_xip_rd_bridge.sv
// Directed bench for spi_xip_rd_bridge with a tiny SPI-controller stand-in.
module tb_spi_xip_rd_bridge;

  logic        clk = 1'b0;
  logic        rstn, cfg_en, cfg_flush;
  logic        bus_req_valid, bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_rsp_valid, bus_rsp_ready, bus_rsp_err;
  logic [31:0] bus_rsp_rdata;
  logic [31:0] spi_cmd, spi_addr;
  logic [5:0]  spi_cmd_len, spi_addr_len;
  logic [15:0] spi_data_len, spi_dummy_rd, spi_dummy_wr;
  logic [3:0]  spi_csreg;
  logic        spi_rd, spi_qrd;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ready, eot, ctrl_idle, busy;

  int errors = 0;
  int checks = 0;

  spi_xip_rd_bridge dut (
    .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .cfg_flush(cfg_flush),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_ready(bus_rsp_ready), .bus_rsp_rdata(bus_rsp_rdata),
    .bus_rsp_err(bus_rsp_err), .spi_cmd(spi_cmd), .spi_cmd_len(spi_cmd_len),
    .spi_addr(spi_addr), .spi_addr_len(spi_addr_len),
    .spi_data_len(spi_data_len), .spi_dummy_rd(spi_dummy_rd),
    .spi_dummy_wr(spi_dummy_wr), .spi_csreg(spi_csreg), .spi_rd(spi_rd),
    .spi_qrd(spi_qrd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .eot(eot), .ctrl_idle(ctrl_idle), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and returns just after the accepting edge.
  task automatic do_req(input logic [31:0] addr, input logic flush);
    int n = 0;
    bus_req_valid = 1'b1;
    bus_req_addr  = addr;
    while (!bus_req_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (bus_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept addr=%h: bus_req_ready=%b expected 1", addr, bus_req_ready);
    end
    cfg_flush = flush;
    step();
    bus_req_valid = 1'b0;
    cfg_flush     = 1'b0;
  endtask

  // Waits (bounded) for a response; does not consume it.
  task automatic wait_rsp(input string name, output logic [31:0] rd, output logic er);
    int n = 0;
    while (!bus_rsp_valid && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (bus_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s rsp_timeout: bus_rsp_valid=%b expected 1", name, bus_rsp_valid);
    end
    rd = bus_rsp_rdata;
    er = bus_rsp_err;
  endtask

  // Controller stand-in: waits for spi_qrd, streams n words, optional eot on the last.
  task automatic ctrl_fill(input string name, input logic [31:0] exp_addr, input int n,
                           input logic [31:0] base, input logic do_eot, input int flush_at);
    int w = 0;
    while (!spi_qrd && w < 20) begin
      step();
      w++;
    end
    checks++;
    if (spi_qrd !== 1'b1) begin
      errors++;
      $display("FAIL %s qrd_timeout: spi_qrd=%b expected 1", name, spi_qrd);
      return;
    end
    checks++;
    if (spi_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s spi_addr: got %h expected %h", name, spi_addr, exp_addr);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (spi_qrd !== 1'b1 || spi_rd !== 1'b0) begin
        errors++;
        $display("FAIL %s qrd_hold word%0d: qrd=%b rd=%b expected 1/0", name, i, spi_qrd, spi_rd);
      end
      rx_valid  = 1'b1;
      rx_data   = base + 32'(i);
      eot       = do_eot && (i == n - 1);
      cfg_flush = (i == flush_at);
      step();
    end
    rx_valid  = 1'b0;
    eot       = 1'b0;
    cfg_flush = 1'b0;
    if (do_eot) begin
      checks++;
      if (spi_qrd !== 1'b0) begin
        errors++;
        $display("FAIL %s qrd_after_eot: got %b expected 0", name, spi_qrd);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; cfg_en = 1'b1; cfg_flush = 1'b0; bus_req_valid = 1'b0;
    bus_req_addr = 32'h0; bus_rsp_ready = 1'b1; rx_data = 32'h0;
    rx_valid = 1'b0; eot = 1'b0; ctrl_idle = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus_req_ready, bus_rsp_valid, bus_rsp_err, spi_qrd, spi_rd, rx_ready, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {bus_req_ready, bus_rsp_valid, bus_rsp_err, spi_qrd, spi_rd, rx_ready, busy});
    end
    checks++;
    if (spi_addr !== 32'h0 || bus_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: spi_addr=%h rdata=%h expected 0/0", spi_addr, bus_rsp_rdata);
    end
    checks++;
    if (spi_cmd !== 32'h0000_00EB || spi_cmd_len !== 6'd8 || spi_addr_len !== 6'd24) begin
      errors++;
      $display("FAIL const_cmd: cmd=%h cmd_len=%0d addr_len=%0d expected eb/8/24",
               spi_cmd, spi_cmd_len, spi_addr_len);
    end
    checks++;
    if (spi_data_len !== 16'd128 || spi_dummy_rd !== 16'd6 || spi_dummy_wr !== 16'd0 ||
        spi_csreg !== 4'b0001) begin
      errors++;
      $display("FAIL const_len: data_len=%0d dummy_rd=%0d dummy_wr=%0d cs=%b expected 128/6/0/0001",
               spi_data_len, spi_dummy_rd, spi_dummy_wr, spi_csreg);
    end
    rstn = 1'b1;
    step();
    checks++;
    if (bus_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", bus_req_ready);
    end
  endtask

  task automatic test_miss();
    logic [31:0] rd;
    logic        er;
    do_req(32'h0000_1234, 1'b0);
    checks++;
    if (busy !== 1'b1 || bus_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL miss_busy: busy=%b rsp_valid=%b expected 1/0", busy, bus_rsp_valid);
    end
    ctrl_fill("miss", 32'h0000_1230, 4, 32'hA0, 1'b1, -1);
    wait_rsp("miss", rd, er);
    checks++;
    if (rd !== 32'hA1 || er !== 1'b0) begin
      errors++;
      $display("FAIL miss_rsp: rdata=%h err=%b expected a1/0", rd, er);
    end
    step();
    checks++;
    if (busy !== 1'b0 || bus_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL miss_done: busy=%b rsp_valid=%b expected 0/0", busy, bus_rsp_valid);
    end
  endtask

  task automatic test_hit();
    logic [31:0] addrs [3] = '{32'h0000_1238, 32'h0000_1230, 32'h0000_123C};
    logic [31:0] exps  [3] = '{32'hA2, 32'hA0, 32'hA3};
    for (int i = 0; i < 3; i++) begin
      do_req(addrs[i], 1'b0);
      checks++;
      if (bus_rsp_valid !== 1'b1 || bus_rsp_rdata !== exps[i] || bus_rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL hit%0d: valid=%b rdata=%h err=%b expected 1/%h/0",
                 i, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err, exps[i]);
      end
      checks++;
      if (spi_qrd !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL hit%0d_nospi: qrd=%b busy=%b expected 0/0", i, spi_qrd, busy);
      end
      step();
    end
  endtask

  task automatic test_window();
    do_req(32'h0100_0000, 1'b0);
    checks++;
    if (bus_rsp_valid !== 1'b1 || bus_rsp_err !== 1'b1 || bus_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL out_of_window: valid=%b err=%b rdata=%h expected 1/1/0",
               bus_rsp_valid, bus_rsp_err, bus_rsp_rdata);
    end
    checks++;
    if (spi_qrd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL window_nospi: qrd=%b busy=%b expected 0/0", spi_qrd, busy);
    end
    step();
    cfg_en = 1'b0;
    do_req(32'h0000_1238, 1'b0);
    checks++;
    if (bus_rsp_valid !== 1'b1 || bus_rsp_err !== 1'b1 || bus_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL disabled: valid=%b err=%b rdata=%h expected 1/1/0",
               bus_rsp_valid, bus_rsp_err, bus_rsp_rdata);
    end
    step();
    cfg_en = 1'b1;
  endtask

  task automatic test_stall();
    bus_rsp_ready = 1'b0;
    do_req(32'h0000_1234, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus_rsp_valid !== 1'b1 || bus_rsp_rdata !== 32'hA1 || bus_rsp_err !== 1'b0 ||
          bus_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall cyc%0d: valid=%b rdata=%h err=%b req_ready=%b expected 1/a1/0/0",
                 i, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err, bus_req_ready);
      end
      step();
    end
    bus_rsp_ready = 1'b1;
    step();
    checks++;
    if (bus_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: rsp_valid=%b expected 0", bus_rsp_valid);
    end
  endtask

  task automatic test_flush_fill();
    logic [31:0] rd;
    logic        er;
    do_req(32'h0000_2000, 1'b0);
    ctrl_fill("flushfill", 32'h0000_2000, 4, 32'hB0, 1'b1, 1);
    wait_rsp("flushfill", rd, er);
    checks++;
    if (rd !== 32'hB0 || er !== 1'b0) begin
      errors++;
      $display("FAIL flushfill_rsp: rdata=%h err=%b expected b0/0", rd, er);
    end
    step();
    do_req(32'h0000_2004, 1'b0);
    checks++;
    if (bus_rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flushfill_refetch: rsp_valid=%b busy=%b expected 0/1", bus_rsp_valid, busy);
    end
    ctrl_fill("refill", 32'h0000_2000, 4, 32'hC0, 1'b1, -1);
    wait_rsp("refill", rd, er);
    checks++;
    if (rd !== 32'hC1 || er !== 1'b0) begin
      errors++;
      $display("FAIL refill_rsp: rdata=%h err=%b expected c1/0", rd, er);
    end
    step();
  endtask

  task automatic test_flush_hit();
    logic [31:0] rd;
    logic        er;
    do_req(32'h0000_200C, 1'b1);
    checks++;
    if (bus_rsp_valid !== 1'b1 || bus_rsp_rdata !== 32'hC3 || bus_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL flush_hit: valid=%b rdata=%h err=%b expected 1/c3/0",
               bus_rsp_valid, bus_rsp_rdata, bus_rsp_err);
    end
    step();
    do_req(32'h0000_2008, 1'b0);
    checks++;
    if (bus_rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_hit_invalidated: rsp_valid=%b busy=%b expected 0/1", bus_rsp_valid, busy);
    end
    ctrl_fill("afterflush", 32'h0000_2000, 4, 32'hE0, 1'b1, -1);
    wait_rsp("afterflush", rd, er);
    checks++;
    if (rd !== 32'hE2 || er !== 1'b0) begin
      errors++;
      $display("FAIL afterflush_rsp: rdata=%h err=%b expected e2/0", rd, er);
    end
    step();
  endtask

  task automatic test_short_fill();
    logic [31:0] rd;
    logic        er;
    ctrl_idle = 1'b0;
    do_req(32'h0000_3000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (spi_qrd !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL issue_wait cyc%0d: qrd=%b busy=%b expected 0/1", i, spi_qrd, busy);
      end
      step();
    end
    ctrl_idle = 1'b1;
    ctrl_fill("short", 32'h0000_3000, 3, 32'hD0, 1'b1, -1);
    wait_rsp("short", rd, er);
    checks++;
    if (rd !== 32'hD0 || er !== 1'b1) begin
      errors++;
      $display("FAIL short_rsp: rdata=%h err=%b expected d0/1", rd, er);
    end
    step();
    do_req(32'h0000_3000, 1'b0);
    checks++;
    if (bus_rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL short_not_cached: rsp_valid=%b busy=%b expected 0/1", bus_rsp_valid, busy);
    end
    ctrl_fill("shortrefill", 32'h0000_3000, 4, 32'hF0, 1'b1, -1);
    wait_rsp("shortrefill", rd, er);
    checks++;
    if (rd !== 32'hF0 || er !== 1'b0) begin
      errors++;
      $display("FAIL shortrefill_rsp: rdata=%h err=%b expected f0/0", rd, er);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    do_req(32'h0000_4004, 1'b0);
    ctrl_fill("midrst", 32'h0000_4000, 2, 32'h50, 1'b0, -1);
    rstn = 1'b0;
    #1;
    checks++;
    if (spi_qrd !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0 || bus_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: qrd=%b busy=%b rx_ready=%b rsp_valid=%b expected 0/0/0/0",
               spi_qrd, busy, rx_ready, bus_rsp_valid);
    end
    step();
    rstn = 1'b1;
    step();
    do_req(32'h0000_3004, 1'b0);
    checks++;
    if (bus_rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_miss: rsp_valid=%b busy=%b expected 0/1", bus_rsp_valid, busy);
    end
    ctrl_fill("postrst", 32'h0000_3000, 4, 32'h60, 1'b1, -1);
    wait_rsp("postrst", rd, er);
    checks++;
    if (rd !== 32'h61 || er !== 1'b0) begin
      errors++;
      $display("FAIL postrst_rsp: rdata=%h err=%b expected 61/0", rd, er);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_window();
    test_stall();
    test_flush_fill();
    test_flush_hit();
    test_short_fill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
